// File: rtl/data_bus_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : data_bus_responder_if
//  Description : CPU data-bus bundle between the core (master) and the
//                memory-side responder (slave). The busErr strobe exists only
//                when DATA_BUS_ERR_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface data_bus_responder_if;

    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [2:0]  busFunct3;
    logic [31:0] busWData;
    logic [31:0] busRData;
    logic        busReady;
`ifdef DATA_BUS_ERR_EN
    logic        busErr;
`endif

`ifdef DATA_BUS_ERR_EN
    // Initiator side: drives the request, observes the response
    modport master (
        output busReq, busWe, busAddr, busFunct3, busWData,
        input  busRData, busReady, busErr
    );

    // Responder side: observes the request, drives the response
    modport slave (
        input  busReq, busWe, busAddr, busFunct3, busWData,
        output busRData, busReady, busErr
    );
`else
    // Initiator side: drives the request, observes the response
    modport master (
        output busReq, busWe, busAddr, busFunct3, busWData,
        input  busRData, busReady
    );

    // Responder side: observes the request, drives the response
    modport slave (
        input  busReq, busWe, busAddr, busFunct3, busWData,
        output busRData, busReady
    );
`endif

endinterface
`default_nettype wire

// File: rtl/data_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : data_bus_responder
//  Description : Memory-side responder for the RV32I data bus. Accepts one
//                load/store at a time, waits WAIT_STATES cycles, then
//                commits the access to a word-organised RAM and strobes
//                busReady for one cycle. Byte/half/word accesses with
//                RV32I funct3 sign/zero extension on loads.
//                Optional feature macro: DATA_BUS_ERR_EN
//                  defined   -> misaligned accesses are rejected with busErr
//                  undefined -> misaligned addresses are forced aligned
//  Revision    : 1.0  initial release
// ============================================================================
module data_bus_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    data_bus_responder_if.slave  bus
);

    localparam int         WORDS     = 1 << (ADDR_WIDTH - 2);
    localparam int         WIDX      = ADDR_WIDTH - 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    state_t                  state_q,  state_d;
    logic [3:0]              cnt_q,    cnt_d;
    logic                    we_q,     we_d;
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [31:0]             wdata_q,  wdata_d;
    logic [31:0]             rdata_q,  rdata_d;
`ifdef DATA_BUS_ERR_EN
    logic                    err_q,    err_d;
`endif

    // Word-organised storage; intentionally not reset
    logic [31:0] mem [WORDS];

    // ------------------------------------------------------------------
    // Effective request: live bus fields while idle (needed when the
    // commit happens on the acceptance edge), captured fields otherwise.
    // ------------------------------------------------------------------
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_f3;
    logic [31:0]           req_wdata;
    logic                  accept;
    logic                  commit;

    // Access decode
    logic                  size_byte;
    logic                  size_half;
    logic                  size_word;
    logic                  misaligned;
    logic [1:0]            lane;
    logic [WIDX-1:0]       word_idx;
    logic [3:0]            byte_en;
    logic [31:0]           wr_lanes;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic                  sign_fill;
    logic [31:0]           load_val;

    // Upper address bits alias onto the RAM and are deliberately dropped
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^bus.busAddr[31:ADDR_WIDTH];

    // Select the request fields that apply to the access being processed
    always_comb begin
        req_we    = we_q;
        req_addr  = addr_q;
        req_f3    = funct3_q;
        req_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            req_we    = bus.busWe;
            req_addr  = bus.busAddr[ADDR_WIDTH-1:0];
            req_f3    = bus.busFunct3;
            req_wdata = bus.busWData;
        end
    end

    // Acceptance and commit-edge qualification
    always_comb begin
        accept = (state_q == ST_IDLE) && bus.busReq;
        commit = (accept && NO_WAIT) ||
                 ((state_q == ST_WAIT) && (cnt_q <= 4'd1));
    end

    // Size, alignment and lane decode for the current request
    always_comb begin
        size_byte  = (req_f3[1:0] == 2'b00);
        size_half  = (req_f3[1:0] == 2'b01);
        size_word  = req_f3[1];
        misaligned = (size_half && req_addr[0]) ||
                     (size_word && (req_addr[1:0] != 2'b00));
        word_idx   = req_addr[ADDR_WIDTH-1:2];
`ifdef DATA_BUS_ERR_EN
        lane       = req_addr[1:0];
`else
        // Misaligned halves/words are silently aligned down
        lane       = size_word ? 2'b00 :
                     size_half ? {req_addr[1], 1'b0} :
                                 req_addr[1:0];
`endif
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        byte_en  = 4'b1111;
        wr_lanes = req_wdata;
        if (size_byte) begin
            byte_en  = 4'b0001 << lane;
            wr_lanes = {4{req_wdata[7:0]}};
        end else if (size_half) begin
            byte_en  = lane[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{req_wdata[15:0]}};
        end
`ifdef DATA_BUS_ERR_EN
        if (misaligned) begin
            byte_en = 4'b0000;
        end
`endif
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        rd_word   = mem[word_idx];
        rd_byte   = rd_word[{lane, 3'b000} +: 8];
        rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        sign_fill = 1'b0;
        load_val  = rd_word;
        if (size_byte) begin
            sign_fill = ~req_f3[2] & rd_byte[7];
            load_val  = {{24{sign_fill}}, rd_byte};
        end else if (size_half) begin
            sign_fill = ~req_f3[2] & rd_half[15];
            load_val  = {{16{sign_fill}}, rd_half};
        end
`ifdef DATA_BUS_ERR_EN
        if (misaligned) begin
            load_val = 32'h0000_0000;
        end
`endif
    end

    // Next-state, request capture and load-result update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef DATA_BUS_ERR_EN
        err_d    = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.busReq) begin
                    we_d     = bus.busWe;
                    addr_d   = bus.busAddr[ADDR_WIDTH-1:0];
                    funct3_d = bus.busFunct3;
                    wdata_d  = bus.busWData;
                    cnt_d    = WAIT_INIT;
                    state_d  = NO_WAIT ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase

        // Loads publish their result on the commit edge; stores keep the
        // previous load value visible (unless rejected as misaligned).
        if (commit) begin
            if (!req_we) begin
                rdata_d = load_val;
            end
`ifdef DATA_BUS_ERR_EN
            err_d = misaligned;
            if (misaligned) begin
                rdata_d = 32'h0000_0000;
            end
`endif
        end
    end

    // Control and request registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
`ifdef DATA_BUS_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
`ifdef DATA_BUS_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    // RAM byte-lane write on the commit edge; blocked while reset is held
    always_ff @(posedge clk) begin
        if (commit && req_we && reset) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    // Response outputs
    assign bus.busReady = (state_q == ST_RESP);
    assign bus.busRData = rdata_q;
`ifdef DATA_BUS_ERR_EN
    assign bus.busErr   = (state_q == ST_RESP) && err_q;
`endif

endmodule
`default_nettype wire

// File: doc/data_bus_responder.md
# data_bus_responder

Memory-side responder for the RV32I CPU data bus: accepts load/store requests issued by the CPU datapath (driven by the control unit's bus write enable), performs byte/half/word accesses on an internal word-organised RAM, and returns load data with a ready handshake after a programmable number of wait states. It sits between the CPU core and the data address space, replacing the zero-latency combinational RAM so the multi-cycle core can be exercised against a memory with real latency.

## Interface
- `ADDR_WIDTH`, 10: byte-address bits decoded; RAM holds 2^(ADDR_WIDTH-2) 32-bit words.
- `WAIT_STATES`, 1: cycles inserted between request acceptance and response, range 0..15.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `busReq` input 1: request valid; initiator holds it and all request fields stable until `busReady`.
- `busWe` input 1: 1 = store, 0 = load.
- `busAddr` input 32: byte address; bits above `ADDR_WIDTH-1` ignored (aliasing).
- `busFunct3` input 3: access size/sign, RV32I funct3 encoding.
- `busWData` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `busRData` output 32: load result, extended to 32 bits.
- `busReady` output 1: one-cycle response strobe.
- `busErr` output 1: misalignment error strobe (present only with `DATA_BUS_ERR_EN`).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `busReq`=1 at a rising edge captures `busWe`, `busAddr`, `busFunct3`, `busWData` into request registers; next state WAIT (or RESP if `WAIT_STATES`=0). Wait counter loaded with `WAIT_STATES`.
- WAIT: counter decrements each cycle; on edge where counter reaches 1 → RESP.
- RESP: `busReady`=1 for exactly this cycle; next state IDLE unconditionally.
- Commit edge = edge entering RESP. Stores write RAM here; loads register `busRData` here.
- Size by funct3[1:0]: 00 byte, 01 half, 10/11 word. Sign: funct3[2]=0 sign-extend, 1 zero-extend (LB/LH/LW/LBU/LHU; 110/111 treated as word).
- Store lanes: byte → lane `addr[1:0]`; half → lane pair `addr[1]`; word → all four. Unselected bytes unchanged.
- Load: select byte/half from the addressed word per same lane rules, then extend.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠00.
- Stores leave `busRData` unchanged; `busRData` holds last load value between transactions.
- RAM contents not reset; undefined until written.

## Timing
- Reset values: state IDLE, `busReady`=0, `busErr`=0, `busRData`=0, counter 0.
- Latency: `busReady` high in cycle N+1+`WAIT_STATES`, where N is the acceptance cycle.
- Minimum back-to-back period: 2+`WAIT_STATES` cycles; request still high in IDLE after RESP is accepted as a new request.
- `busReq` while not IDLE is ignored; field changes after acceptance have no effect.
- Reset asserted mid-transaction: aborts immediately; store not yet at commit edge is never written; no `busReady` issued.
- Store followed immediately by load of same address returns the new data.

## Configuration
- `DATA_BUS_ERR_EN` defined: misaligned access suppresses RAM write, sets `busRData`=0 at commit edge, and asserts `busErr`=1 together with `busReady` in RESP; `busErr` is 0 at all other times.
- Not defined: `busErr` port absent; misaligned addresses are forced aligned (half: addr[0] cleared; word: addr[1:0] cleared) and the access completes normally.

## Test plan
- Reset then SW 0xDEADBEEF to 0x010, WAIT_STATES=1 → `busReady` in cycle N+2; LW 0x010 → `busRData`=0xDEADBEEF.
- SB 0x7F to 0x011 over 0xDEADBEEF, then LB 0x011 → 0x0000007F, LBU 0x013 → 0x000000DE, LB 0x013 → 0xFFFFFFDE, LW 0x010 → 0xDEAD7FEF.
- SH 0x8001 to 0x022, LH 0x022 → 0xFFFF8001, LHU 0x022 → 0x00008001; word 0x020 upper half = 0x8001.
- WAIT_STATES=0, busReq held high over 3 LWs → `busReady` every 2nd cycle, each with correct data.
- Reset pulsed while in WAIT of SW 0x12345678 to 0x030 → no `busReady`; later LW 0x030 returns prior contents.
- LW 0x031: with `DATA_BUS_ERR_EN` → `busErr`=1, `busReady`=1, `busRData`=0, RAM unchanged; without → returns word at 0x030.
